// File: rtl/stop_watch_timer_pkg.sv
// Shared types and constants for the M:SS.T stopwatch/timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stop_watch_pkg;

    // Width of one BCD digit.
    localparam int DIGIT_W = 4;

    // Upper limit of each fixed-range digit (tenths, seconds, tens of seconds).
    localparam int D0_MAX = 9;
    localparam int D1_MAX = 9;
    localparam int D2_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stop_watch_timer_bcd_digit_cnt.sv
// One BCD digit, counting 0..MAX up or down, with clear, clamped load and carry/borrow out.
// Latency: q updates on the edge after en/clr/ld; cb is combinational from q and en.
// Backpressure: none; en is a single-cycle advance request that is always honoured.
//
// Ports: clk, rst_n (async active-low), en (advance), dir (1 = down), clr, ld,
//        ld_val (values above MAX clamp to MAX), q (digit), cb (carry when wrapping
//        up from MAX, borrow when wrapping down from 0).
module bcd_digit_cnt
    import stop_watch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] q,
    output logic               cb
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);
    localparam logic [DIGIT_W-1:0] ONE_V = DIGIT_W'(1);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = (ld_val > MAX_V) ? MAX_V : ld_val;
        end else if (en) begin
            if (dir) begin
                q_d = (q_q == '0) ? MAX_V : q_q - ONE_V;
            end else begin
                q_d = (q_q == MAX_V) ? '0 : q_q + ONE_V;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign cb = en && (dir ? (q_q == '0) : (q_q == MAX_V));

endmodule

// File: rtl/stop_watch_timer.sv
// M:SS.T stopwatch (count up) / preset timer (count down) with lap capture and done flag.
// Latency: 1 cycle from any control pulse to its visible effect; digits advance on the tick edge.
// Backpressure: none; every pulse is acted on or ignored in the cycle it is presented.
//
// Ports: clk, rst_n (async active-low); start/stop/clr/load/lap control pulses;
//        mode_down (latched on start from IDLE); load_val BCD {d3,d2,d1,d0};
//        d3..d0 digits; lap_d/lap_valid captured lap; running, done, tick status.
// Build option: define STOP_WATCH_SAT_EN to make up-counting stop at MIN_MAX:59.9
//        and enter DONE instead of wrapping to 0:00.0.
module stop_watch_timer
    import stop_watch_pkg::*;
#(
    parameter int DVSR    = 10_000_000,
    parameter int MIN_MAX = 9,
    parameter int PW      = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         clr,
    input  logic         mode_down,
    input  logic         load,
    input  logic [15:0]  load_val,
    input  logic         lap,
    output logic [3:0]   d3,
    output logic [3:0]   d2,
    output logic [3:0]   d1,
    output logic [3:0]   d0,
    output logic [15:0]  lap_d,
    output logic         lap_valid,
    output logic         running,
    output logic         done,
    output logic         tick
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mode_q, mode_d;
    logic [15:0]   lap_cap_q, lap_cap_d;
    logic          lap_valid_q, lap_valid_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic [15:0]   digits;
    logic          tick_int;
    logic          ld_acc;
    logic          is_zero;
    logic          dn_end;
    logic          sat_hit;
    logic          en0;
    logic          cb0, cb1, cb2;
    logic          cb3_unused;

    assign digits   = {d3, d2, d1, d0};
    assign is_zero  = (digits == 16'h0000);
    assign tick_int = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign ld_acc   = load && !clr && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    // The tick that moves 0:00.1 to 0:00.0 in down mode is the terminal one.
    assign dn_end   = tick_int && mode_q && (digits == 16'h0001);

`ifdef STOP_WATCH_SAT_EN
    logic at_max;
    assign at_max  = !mode_q && (d3 == DIGIT_W'(MIN_MAX)) && (d2 == DIGIT_W'(D2_MAX)) &&
                     (d1 == DIGIT_W'(D1_MAX)) && (d0 == DIGIT_W'(D0_MAX));
    assign sat_hit = tick_int && at_max;
`else
    assign sat_hit = 1'b0;
`endif

    // Suppressing the first stage on saturation freezes the whole chain.
    assign en0 = tick_int && !sat_hit;

    bcd_digit_cnt #(.MAX(D0_MAX)) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .dir(mode_q), .clr(clr), .ld(ld_acc),
        .ld_val(load_val[3:0]), .q(d0), .cb(cb0)
    );
    bcd_digit_cnt #(.MAX(D1_MAX)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(cb0), .dir(mode_q), .clr(clr), .ld(ld_acc),
        .ld_val(load_val[7:4]), .q(d1), .cb(cb1)
    );
    bcd_digit_cnt #(.MAX(D2_MAX)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(cb1), .dir(mode_q), .clr(clr), .ld(ld_acc),
        .ld_val(load_val[11:8]), .q(d2), .cb(cb2)
    );
    bcd_digit_cnt #(.MAX(MIN_MAX)) u_d3 (
        .clk(clk), .rst_n(rst_n), .en(cb2), .dir(mode_q), .clr(clr), .ld(ld_acc),
        .ld_val(load_val[15:12]), .q(d3), .cb(cb3_unused)
    );

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        lap_cap_d   = lap_cap_q;
        lap_valid_d = lap_valid_q;

        if (clr) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            lap_cap_d   = '0;
            lap_valid_d = 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = tick_int ? '0 : presc_q + PW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    // A down-mode start with nothing left to count finishes at once.
                    if (!ld_acc && !stop && start) begin
                        mode_d  = mode_down;
                        presc_d = '0;
                        state_d = (mode_down && is_zero) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Reaching the end wins over a coincident stop.
                    if (dn_end || sat_hit) begin
                        state_d = ST_DONE;
                    end else if (stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!ld_acc && !stop && start) begin
                        state_d = (mode_q && is_zero) ? ST_DONE : ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase

            if (ld_acc) begin
                presc_d = '0;
            end

            // Captures the pre-tick value when a tick lands in the same cycle.
            if (lap && !ld_acc && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
                lap_cap_d   = digits;
                lap_valid_d = 1'b1;
            end
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            mode_q      <= 1'b0;
            lap_cap_q   <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            lap_cap_q   <= lap_cap_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign lap_d     = lap_cap_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign done      = done_q;
    assign tick      = tick_int;

endmodule
